// File: rtl/dot_acc_pkg.sv
// Shared types and default parameters for the dot-product accumulator.
// Optional saturating accumulation is selected with DOT_ACC_SAT_EN.
package dot_acc_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  localparam int PROD_W_D     = 16;
  localparam int K_D          = 4;
  localparam int ACC_W_D      = 20;
  localparam int FIFO_DEPTH_D = 4;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO for completed dot-product results.
// When empty, dout keeps showing the last value popped (zero after reset).
module result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
  logic [CNT_W-1:0] countQ;
  logic [WIDTH-1:0] lastQ;
  logic             doPush, doPop;

  assign empty = (countQ == '0);
  assign full  = (countQ == CNT_W'(DEPTH));
  assign count = countQ;
  assign doPop  = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? lastQ : memQ[rdPtrQ];

  always_ff @(posedge clk) begin
    if (doPush) memQ[wrPtrQ] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      lastQ  <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
        lastQ  <= memQ[rdPtrQ];
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/dot_prod_accum.sv
// Sums every K valid products into one result and queues results in a FWFT FIFO.
// Define DOT_ACC_SAT_EN to clamp each addition at 2^ACC_W-1 instead of wrapping.
module dot_prod_accum
  import dot_acc_pkg::*;
#(
  parameter int PROD_W     = PROD_W_D,
  parameter int K          = K_D,
  parameter int ACC_W      = ACC_W_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PROD_W-1:0]                 product_in,
  input  logic                              valid_in,
  input  logic                              flush,
  output logic [ACC_W-1:0]                  res_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntEff;
  logic [ACC_W-1:0] acc_q, acc_d, prodExt, base, sum;
  logic             overflow_q, overflow_d;
  logic             groupStart, pushRes, popRes, fifoEmpty, fifoFull;

  // A flush makes this cycle look like the start of a fresh group.
  always_comb begin
    prodExt    = ACC_W'(product_in);
    groupStart = flush || (state_q == IDLE);
    cntEff     = groupStart ? '0 : cnt_q;
    base       = groupStart ? '0 : acc_q;
`ifdef DOT_ACC_SAT_EN
    begin
      logic [ACC_W:0] sumWide;
      sumWide = {1'b0, base} + {1'b0, prodExt};
      sum     = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
    end
`else
    sum = base + prodExt;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pushRes = 1'b0;
    if (valid_in) begin
      if (cntEff == LAST) begin
        pushRes = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = sum;
        cnt_d   = cntEff + 1'b1;
        state_d = ACCUM;
      end
    end else if (flush) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign res_valid  = !fifoEmpty;
  assign popRes     = res_valid && res_ready;
  assign overflow_d = overflow_q || (pushRes && fifoFull && !popRes);
  assign overflow   = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  result_fifo #(
    .WIDTH(ACC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pushRes),
    .pop  (popRes),
    .din  (sum),
    .dout (res_data),
    .empty(fifoEmpty),
    .full (fifoFull),
    .count(fifo_count)
  );

endmodule
